multicycle_control_unit: RTL and testbench

Moore-style control FSM that turns the single-cycle RISC-V datapath into a multi-cycle one. It sequences fetch, decode, execute, memory and write-back over several clocks, and drives the ALU operation code, the operand and result muxes, and all architectural write strobes. It sits between the instruction register (opcode/funct fields) and the datapath, and consumes the ALU `Zero_o` flag for branches. Supported subset: add, addi, lw, sw, beq, jal, lui. Any other encoding halts the core.

---
 rtl/multicycle_control_unit.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V control FSM.
// Sequences fetch / decode / execute / memory / write-back for the
// add, addi, lw, sw, beq, jal and lui subset. It drives the datapath
// mux selects, the ALU operation and every architectural write strobe.
// Any other encoding parks the FSM in ERROR until the next reset.
//
// The control outputs that depend only on the state are registered. Each
// one is loaded with the decode of the state being entered, so it always
// matches state_q. Two outputs are combinational on purpose:
//   * imm_src_o depends on the live opcode in DECODE and MEMADR. The IR
//     only reloads on the FETCH->DECODE edge, so the new opcode cannot
//     be known one cycle early.
//   * pc_write_o in BEQ follows zero_i, which settles inside that cycle.
// While reset is low, every output is forced to zero combinationally.
module multicycle_control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       zero_i,
    output logic       pc_write_o,
    output logic       ir_write_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic       adr_src_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] result_src_o,
    output logic [2:0] imm_src_o,
    output logic [3:0] alu_operation_o,
    output logic [3:0] state_o,
    output logic       error_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_EXECLUI  = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_JAL      = 4'd11,
        S_ERROR    = 4'd15
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_LUI = 4'b0010;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Control outputs that are a pure function of the state.
    // "branch" marks the BEQ cycle, where pc_write follows zero_i.
    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [3:0] alu_op;
        logic       error;
    } ctrl_t;

    // Gives the state-only control word for one state. Every field
    // defaults to zero; each case item lists only the non-zero fields.
    function automatic ctrl_t state_ctrl(input state_e st);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_write   = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALU_ADD;
                c.result_src = RES_ALU;
            end
            S_DECODE: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_IMM;
                c.alu_op     = ALU_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a  = SRCA_RD1;
                c.alu_src_b  = SRCB_IMM;
                c.alu_op     = ALU_ADD;
            end
            S_MEMREAD: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                c.result_src = RES_MEM;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
                c.mem_write  = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a  = SRCA_RD1;
                c.alu_src_b  = SRCB_RD2;
                c.alu_op     = ALU_ADD;
            end
            S_EXECI: begin
                c.alu_src_a  = SRCA_RD1;
                c.alu_src_b  = SRCB_IMM;
                c.alu_op     = ALU_ADD;
            end
            S_EXECLUI: begin
                c.alu_src_b  = SRCB_IMM;
                c.alu_op     = ALU_LUI;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a  = SRCA_RD1;
                c.alu_src_b  = SRCB_RD2;
                c.alu_op     = ALU_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALU_ADD;
                c.result_src = RES_ALUOUT;
                c.pc_write   = 1'b1;
            end
            S_ERROR: begin
                c.error      = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    // Picks the state after DECODE. A supported opcode whose funct
    // fields do not match the subset is treated as illegal.
    function automatic state_e decode_next(input logic [6:0] op,
                                           input logic [2:0] f3,
                                           input logic       f7b5);
        state_e nxt;
        case (op)
            OP_LOAD, OP_STORE: nxt = (f3 == 3'b010) ? S_MEMADR : S_ERROR;
            OP_RTYPE:          nxt = ((f3 == 3'b000) && (f7b5 == 1'b0)) ? S_EXECR : S_ERROR;
            OP_ITYPE:          nxt = (f3 == 3'b000) ? S_EXECI : S_ERROR;
            OP_LUI:            nxt = S_EXECLUI;
            OP_BRANCH:         nxt = (f3 == 3'b000) ? S_BEQ : S_ERROR;
            OP_JAL:            nxt = S_JAL;
            default:           nxt = S_ERROR;
        endcase
        return nxt;
    endfunction

    state_e     state_q;
    state_e     state_d;
    ctrl_t      ctrl_q;
    logic [2:0] imm_src_s;

    // Next-state logic. Unused codes and anything unexpected go to ERROR.
    always_comb begin
        state_d = S_ERROR;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE:   state_d = decode_next(opcode_i, funct3_i, funct7b5_i);
            S_MEMADR: begin
                if (opcode_i == OP_LOAD) begin
                    state_d = S_MEMREAD;
                end else if (opcode_i == OP_STORE) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_ERROR;
                end
            end
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_EXECLUI:  state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_ERROR:    state_d = S_ERROR;
            default:    state_d = S_ERROR;
        endcase
    end

    // State register plus registered control word for the state being entered.
    // The control word resets to the FETCH pattern so it matches state_q after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= state_ctrl(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d);
        end
    end

    // Immediate format. DECODE and MEMADR need the opcode currently held in the IR.
    always_comb begin
        imm_src_s = IMM_I;
        case (state_q)
            S_DECODE: begin
                if (opcode_i == OP_BRANCH) begin
                    imm_src_s = IMM_B;
                end else if (opcode_i == OP_JAL) begin
                    imm_src_s = IMM_J;
                end else begin
                    imm_src_s = IMM_I;
                end
            end
            S_MEMADR: begin
                if (opcode_i == OP_STORE) begin
                    imm_src_s = IMM_S;
                end else begin
                    imm_src_s = IMM_I;
                end
            end
            S_EXECI:   imm_src_s = IMM_I;
            S_EXECLUI: imm_src_s = IMM_U;
            default:   imm_src_s = IMM_I;
        endcase
    end

    // Output stage. While reset is low, everything is held at zero.
    // In BEQ, pc_write follows zero_i combinationally.
    always_comb begin
        if (reset) begin
            pc_write_o      = ctrl_q.pc_write | (ctrl_q.branch & zero_i);
            ir_write_o      = ctrl_q.ir_write;
            mem_write_o     = ctrl_q.mem_write;
            reg_write_o     = ctrl_q.reg_write;
            adr_src_o       = ctrl_q.adr_src;
            alu_src_a_o     = ctrl_q.alu_src_a;
            alu_src_b_o     = ctrl_q.alu_src_b;
            result_src_o    = ctrl_q.result_src;
            imm_src_o       = imm_src_s;
            alu_operation_o = ctrl_q.alu_op;
            state_o         = state_q;
            error_o         = ctrl_q.error;
        end else begin
            pc_write_o      = 1'b0;
            ir_write_o      = 1'b0;
            mem_write_o     = 1'b0;
            reg_write_o     = 1'b0;
            adr_src_o       = 1'b0;
            alu_src_a_o     = 2'b00;
            alu_src_b_o     = 2'b00;
            result_src_o    = 2'b00;
            imm_src_o       = 3'b000;
            alu_operation_o = 4'b0000;
            state_o         = 4'b0000;
            error_o         = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit.
// The reference model maps each instruction class to its documented state path.
// It derives every cycle's expected control vector from the per-state output table.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode_i;
    logic [2:0] funct3_i;
    logic       funct7b5_i;
    logic       zero_i;
    logic       pc_write_o;
    logic       ir_write_o;
    logic       mem_write_o;
    logic       reg_write_o;
    logic       adr_src_o;
    logic [1:0] alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [1:0] result_src_o;
    logic [2:0] imm_src_o;
    logic [3:0] alu_operation_o;
    logic [3:0] state_o;
    logic       error_o;

    int errors = 0;
    int checks = 0;
    int path_q[$];

    localparam int K_ADD  = 0;
    localparam int K_ADDI = 1;
    localparam int K_LW   = 2;
    localparam int K_SW   = 3;
    localparam int K_BEQ  = 4;
    localparam int K_JAL  = 5;
    localparam int K_LUI  = 6;
    localparam int K_ILL  = 7;

    localparam logic [22:0] ALL_ZERO = 23'd0;

    // Table of illegal encodings: {opcode, funct3, funct7b5}.
    logic [10:0] bad_tbl [8] = '{
        {7'b1110011, 3'b000, 1'b0}, {7'b0000000, 3'b000, 1'b0},
        {7'b0110011, 3'b001, 1'b0}, {7'b0110011, 3'b000, 1'b1},
        {7'b0000011, 3'b000, 1'b0}, {7'b0100011, 3'b011, 1'b0},
        {7'b1100011, 3'b001, 1'b0}, {7'b0010011, 3'b111, 1'b0}
    };

    wire [22:0] obs_s = {pc_write_o, ir_write_o, mem_write_o, reg_write_o, adr_src_o,
                         alu_src_a_o, alu_src_b_o, result_src_o, imm_src_o,
                         alu_operation_o, state_o, error_o};

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk             (clk),
        .reset           (reset),
        .opcode_i        (opcode_i),
        .funct3_i        (funct3_i),
        .funct7b5_i      (funct7b5_i),
        .zero_i          (zero_i),
        .pc_write_o      (pc_write_o),
        .ir_write_o      (ir_write_o),
        .mem_write_o     (mem_write_o),
        .reg_write_o     (reg_write_o),
        .adr_src_o       (adr_src_o),
        .alu_src_a_o     (alu_src_a_o),
        .alu_src_b_o     (alu_src_b_o),
        .result_src_o    (result_src_o),
        .imm_src_o       (imm_src_o),
        .alu_operation_o (alu_operation_o),
        .state_o         (state_o),
        .error_o         (error_o)
    );

    // Expected control vector for one state of the documented output table.
    function automatic logic [22:0] exp_vec(input int st, input logic [6:0] op, input logic z);
        logic pcw, irw, mw, rw, adr, err;
        logic [1:0] sa, sb, rs;
        logic [2:0] imm;
        logic [3:0] alu, stc;
        {pcw, irw, mw, rw, adr, err} = 6'b000000;
        sa = 2'b00; sb = 2'b00; rs = 2'b00; imm = 3'b000; alu = 4'b0000;
        stc = st[3:0];
        case (st)
            0:  begin irw = 1'b1; pcw = 1'b1; sb = 2'b10; rs = 2'b10; end
            1:  begin
                    sa = 2'b01; sb = 2'b01;
                    imm = (op == 7'b1100011) ? 3'b010 : ((op == 7'b1101111) ? 3'b011 : 3'b000);
                end
            2:  begin sa = 2'b10; sb = 2'b01; imm = (op == 7'b0100011) ? 3'b001 : 3'b000; end
            3:  adr = 1'b1;
            4:  begin rs = 2'b01; rw = 1'b1; end
            5:  begin adr = 1'b1; mw = 1'b1; end
            6:  sa = 2'b10;
            7:  begin sa = 2'b10; sb = 2'b01; end
            8:  begin sb = 2'b01; imm = 3'b100; alu = 4'b0010; end
            9:  rw = 1'b1;
            10: begin sa = 2'b10; alu = 4'b0001; pcw = z; end
            11: begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
            15: err = 1'b1;
            default: err = 1'b0;
        endcase
        return {pcw, irw, mw, rw, adr, sa, sb, rs, imm, alu, stc, err};
    endfunction

    // State path of one instruction, starting at FETCH.
    task automatic fill_path(input int kind);
        path_q = {};
        case (kind)
            K_ADD:  path_q = '{0, 1, 6, 9};
            K_ADDI: path_q = '{0, 1, 7, 9};
            K_LW:   path_q = '{0, 1, 2, 3, 4};
            K_SW:   path_q = '{0, 1, 2, 5};
            K_BEQ:  path_q = '{0, 1, 10};
            K_JAL:  path_q = '{0, 1, 11, 9};
            K_LUI:  path_q = '{0, 1, 8, 9};
            default: begin
                path_q = '{0, 1};
                for (int i = 0; i < 12; i++) path_q.push_back(15);
            end
        endcase
    endtask

    task automatic check_vec(input string tag, input logic [22:0] exp);
        checks++;
        assert (obs_s === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs_s, exp);
        end
    endtask

    // Pulse reset away from the clock edge and check that every output drops at once.
    task automatic reset_pulse(input string tag);
        #2 reset = 1'b0;
        zero_i = 1'b1;
        #1 check_vec(tag, ALL_ZERO);
        @(negedge clk);
        check_vec({tag, "_held"}, ALL_ZERO);
        reset = 1'b1;
    endtask

    // Runs one instruction, starting at the negedge of its FETCH cycle.
    // zsel: 0/1 forces zero_i, and 2 randomises it every cycle.
    // abort_at >= 0 asserts reset in that path step.
    task automatic run_instr(input int kind, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input int zsel, input int abort_at);
        fill_path(kind);
        opcode_i = op; funct3_i = f3; funct7b5_i = f7;
        for (int i = 0; i < path_q.size(); i++) begin
            zero_i = (zsel == 2) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            #1;
            check_vec($sformatf("k%0d_step%0d_st%0d", kind, i, path_q[i]),
                      exp_vec(path_q[i], op, zero_i));
            if (i == abort_at) begin
                reset_pulse($sformatf("k%0d_abort", kind));
                return;
            end
            @(negedge clk);
        end
    endtask

    // Legal encoding of an instruction class; don't-care fields are randomised.
    task automatic legal_enc(input int kind, output logic [6:0] op, output logic [2:0] f3,
                             output logic f7);
        f3 = 3'($urandom_range(0, 7));
        f7 = 1'($urandom_range(0, 1));
        case (kind)
            K_ADD:  begin op = 7'b0110011; f3 = 3'b000; f7 = 1'b0; end
            K_ADDI: begin op = 7'b0010011; f3 = 3'b000; end
            K_LW:   begin op = 7'b0000011; f3 = 3'b010; end
            K_SW:   begin op = 7'b0100011; f3 = 3'b010; end
            K_BEQ:  begin op = 7'b1100011; f3 = 3'b000; end
            K_JAL:  op = 7'b1101111;
            default: op = 7'b0110111;
        endcase
    endtask

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [10:0] bad;
        int         kind;

        reset = 1'b0; zero_i = 1'b1;
        opcode_i = 7'b0110011; funct3_i = 3'b000; funct7b5_i = 1'b0;
        #3 check_vec("reset_t3", ALL_ZERO);
        repeat (2) @(negedge clk);
        check_vec("reset_held", ALL_ZERO);
        reset = 1'b1;

        // Directed: add, lw, beq taken and not taken, lui, jal, sw, addi.
        run_instr(K_ADD,  7'b0110011, 3'b000, 1'b0, 2, -1);
        run_instr(K_LW,   7'b0000011, 3'b010, 1'b0, 2, -1);
        run_instr(K_BEQ,  7'b1100011, 3'b000, 1'b0, 1, -1);
        run_instr(K_BEQ,  7'b1100011, 3'b000, 1'b0, 0, -1);
        run_instr(K_LUI,  7'b0110111, 3'b101, 1'b1, 2, -1);
        run_instr(K_JAL,  7'b1101111, 3'b011, 1'b0, 2, -1);
        run_instr(K_SW,   7'b0100011, 3'b010, 1'b0, 2, -1);
        run_instr(K_ADDI, 7'b0010011, 3'b000, 1'b1, 2, -1);

        // Illegal opcode, then add with funct7b5 set; each is recovered by reset.
        run_instr(K_ILL, 7'b1110011, 3'b000, 1'b0, 2, -1);
        reset_pulse("ill_opcode_reset");
        run_instr(K_ILL, 7'b0110011, 3'b000, 1'b1, 2, -1);
        reset_pulse("ill_funct7_reset");

        // Reset in the MEMWRITE cycle of sw, then resume with an add.
        run_instr(K_SW,  7'b0100011, 3'b010, 1'b0, 2, 3);
        run_instr(K_ADD, 7'b0110011, 3'b000, 1'b0, 2, -1);

        // Random instruction stream with occasional illegal encodings.
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 7);
            if (kind == K_ILL) begin
                bad = bad_tbl[$urandom_range(0, 7)];
                run_instr(K_ILL, bad[10:4], bad[3:1], bad[0], 2, -1);
                reset_pulse("rand_ill_reset");
            end else begin
                legal_enc(kind, op, f3, f7);
                run_instr(kind, op, f3, f7, 2, -1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
